// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Owns pc and the instruction register; every control output is a registered Moore output.
module core_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] target,
    input  logic        br_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_b_sel,
    output logic        retire,
    output logic [31:0] instret,
    output logic        illegal,
    output logic [2:0]  state
);

    // state  | meaning
    // FETCH  | imem_req high, waiting for imem_ready; pc is the fetch address
    // DECODE | decoder settles on instr, class latched, illegal opcodes trapped
    // EXEC   | ALU operates; branches resolve and retire here
    // MEM    | dmem_req high, waiting for dmem_ready
    // WB     | rf_we high, pc advanced or redirected, instruction retires
    // HALT   | fault; everything idle until reset
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
    } cls_t;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       alu_b_sel;
    } ctl_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      st;
    cls_t        cls;
    ctl_t        ctl_q;
    logic [31:0] pc_inc;
    logic        tgt_misaligned;
    logic        unused_func3;

    assign state          = st;
    assign pc_inc         = pc + 32'd4;
    assign tgt_misaligned = (target[1:0] != 2'b00);
    // func3 goes straight from the decoder to the memory as access size
    assign unused_func3   = ^func3;

    assign imem_req  = ctl_q.imem_req;
    assign dmem_req  = ctl_q.dmem_req;
    assign dmem_we   = ctl_q.dmem_we;
    assign rf_we     = ctl_q.rf_we;
    assign wb_sel    = ctl_q.wb_sel;
    assign alu_b_sel = ctl_q.alu_b_sel;

    function automatic cls_t classify(input logic [6:0] op);
        cls_t c;
        case (op)
            7'b0110011: c = C_R;
            7'b0010011: c = C_IALU;
            7'b0000011: c = C_LOAD;
            7'b0100011: c = C_STORE;
            7'b1100011: c = C_BRANCH;
            7'b1101111: c = C_JAL;
            7'b1100111: c = C_JALR;
            7'b0110111: c = C_LUI;
            7'b0010111: c = C_AUIPC;
            default:    c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic uses_imm(input cls_t c);
        return (c == C_IALU) || (c == C_LOAD) || (c == C_STORE) ||
               (c == C_JALR) || (c == C_LUI)  || (c == C_AUIPC);
    endfunction

    // Operand B stays selected through MEM and WB so the address / result stays valid.
    function automatic ctl_t ctl_for(input state_t s, input cls_t c);
        ctl_t o;
        o = '0;
        case (s)
            S_FETCH: o.imem_req = 1'b1;
            S_EXEC:  o.alu_b_sel = uses_imm(c);
            S_MEM: begin
                o.dmem_req  = 1'b1;
                o.dmem_we   = (c == C_STORE);
                o.alu_b_sel = uses_imm(c);
            end
            S_WB: begin
                o.rf_we     = 1'b1;
                o.alu_b_sel = uses_imm(c);
                if (c == C_LOAD)
                    o.wb_sel = 2'b01;
                else if ((c == C_JAL) || (c == C_JALR))
                    o.wb_sel = 2'b10;
                else
                    o.wb_sel = 2'b00;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= S_FETCH;
            cls     <= C_IALU;
            pc      <= RESET_PC;
            instr   <= NOP;
            illegal <= 1'b0;
            instret <= 32'd0;
            retire  <= 1'b0;
            ctl_q   <= ctl_for(S_FETCH, C_IALU);
        end else begin
            retire <= 1'b0;
            case (st)
                S_FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        st    <= S_DECODE;
                        ctl_q <= ctl_for(S_DECODE, cls);
                    end
                end
                S_DECODE: begin
                    cls <= classify(opcode);
                    if (classify(opcode) == C_ILL) begin
                        illegal <= 1'b1;
                        st      <= S_HALT;
                        ctl_q   <= ctl_for(S_HALT, C_ILL);
                    end else begin
                        st    <= S_EXEC;
                        ctl_q <= ctl_for(S_EXEC, classify(opcode));
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_LOAD, C_STORE: begin
                            st    <= S_MEM;
                            ctl_q <= ctl_for(S_MEM, cls);
                        end
                        C_BRANCH: begin
                            if (br_taken && tgt_misaligned) begin
                                illegal <= 1'b1;
                                st      <= S_HALT;
                                ctl_q   <= ctl_for(S_HALT, cls);
                            end else begin
                                pc      <= br_taken ? target : pc_inc;
                                retire  <= 1'b1;
                                instret <= instret + 32'd1;
                                st      <= S_FETCH;
                                ctl_q   <= ctl_for(S_FETCH, cls);
                            end
                        end
                        C_JAL, C_JALR: begin
                            // A misaligned jump never reaches a live WB: no rf_we, no retire.
                            if (tgt_misaligned) begin
                                illegal <= 1'b1;
                                st      <= S_HALT;
                                ctl_q   <= ctl_for(S_HALT, cls);
                            end else begin
                                st    <= S_WB;
                                ctl_q <= ctl_for(S_WB, cls);
                            end
                        end
                        default: begin
                            st    <= S_WB;
                            ctl_q <= ctl_for(S_WB, cls);
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (cls == C_STORE) begin
                            pc      <= pc_inc;
                            retire  <= 1'b1;
                            instret <= instret + 32'd1;
                            st      <= S_FETCH;
                            ctl_q   <= ctl_for(S_FETCH, cls);
                        end else begin
                            st    <= S_WB;
                            ctl_q <= ctl_for(S_WB, cls);
                        end
                    end
                end
                S_WB: begin
                    pc      <= ((cls == C_JAL) || (cls == C_JALR)) ? target : pc_inc;
                    retire  <= 1'b1;
                    instret <= instret + 32'd1;
                    st      <= S_FETCH;
                    ctl_q   <= ctl_for(S_FETCH, cls);
                end
                S_HALT: begin
                    st    <= S_HALT;
                    ctl_q <= ctl_for(S_HALT, cls);
                end
                default: begin
                    illegal <= 1'b1;
                    st      <= S_HALT;
                    ctl_q   <= ctl_for(S_HALT, cls);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: scoreboard bench for core_ctrl; a driver plays memory and datapath,
// a monitor checks retire / writeback events against a queue of model predictions.
module tb_core_ctrl;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc, instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] target = 32'h0;
    logic        br_taken = 1'b0;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic        rf_we, alu_b_sel, retire, illegal;
    logic [1:0]  wb_sel;
    logic [31:0] instret;
    logic [2:0]  state;

    core_ctrl #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .opcode(opcode), .func3(func3),
        .target(target), .br_taken(br_taken), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .rf_we(rf_we), .wb_sel(wb_sel), .alu_b_sel(alu_b_sel),
        .retire(retire), .instret(instret), .illegal(illegal), .state(state)
    );

    // decoder stand-in
    assign opcode = instr[6:0];
    assign func3  = instr[14:12];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [31:0] cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] wb_q[$];
    logic       exp_alub = 1'b0;
    logic [31:0] m_pc = RPC;
    logic [31:0] m_instret = 32'd0;
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 8))
            0: return OP_R;   1: return OP_I;    2: return OP_LD;
            3: return OP_ST;  4: return OP_BR;   5: return OP_JAL;
            6: return OP_JALR; 7: return OP_LUI; default: return OP_AUIPC;
        endcase
    endfunction

    // which: 0 imem_req, 1 dmem_req, 2 retire, 3 state==HALT
    task automatic wait_for(input int which, input int lim, input string name);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < lim; k++) begin
            case (which)
                0: hit = imem_req;
                1: hit = dmem_req;
                2: hit = retire;
                default: hit = (state == 3'd5);
            endcase
            if (hit) break;
            @(negedge clk);
        end
        check(name, {31'd0, hit}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_pc = RPC;
        m_instret = 32'd0;
        exp_q.delete();
        wb_q.delete();
        check("rst_pc", pc, RPC);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd1);
        check("rst_ctl", {24'd0, illegal, retire, rf_we, dmem_req, dmem_we, wb_sel, alu_b_sel}, 32'd0);
        check("rst_instret", instret, 32'd0);
    endtask

    task automatic run_instr(input logic [31:0] w, input logic tk, input logic [31:0] tg,
                             input int iw, input int dw);
        logic [6:0]  op;
        logic        legal, redirect, halt_exp, is_mem;
        logic [31:0] npc;
        int          len, t0;
        exp_t        e;
        op       = w[6:0];
        legal    = is_legal(op);
        is_mem   = (op == OP_LD) || (op == OP_ST);
        redirect = ((op == OP_BR) && tk) || (op == OP_JAL) || (op == OP_JALR);
        npc      = redirect ? tg : m_pc + 32'd4;
        halt_exp = !legal || (redirect && (tg[1:0] != 2'b00));
        len      = ((op == OP_BR) ? 3 : (op == OP_LD) ? 5 : 4) + iw + (is_mem ? dw : 0);

        wait_for(0, 60, "imem_req_wait");
        t0 = cyc;
        check("fetch_pc", pc, m_pc);
        target   = tg;
        br_taken = tk;
        exp_alub = op inside {OP_I, OP_LD, OP_ST, OP_JALR, OP_LUI, OP_AUIPC};
        if (!halt_exp) begin
            e.pc = npc; e.cnt = m_instret + 32'd1; e.cyc = t0 + len;
            exp_q.push_back(e);
            if (!(op inside {OP_BR, OP_ST}))
                wb_q.push_back((op == OP_LD) ? 2'b01 : (op inside {OP_JAL, OP_JALR}) ? 2'b10 : 2'b00);
        end
        for (int k = 0; k < iw; k++) begin
            @(negedge clk);
            check("imem_req_hold", {31'd0, imem_req}, 32'd1);
            check("pc_stable", pc, m_pc);
        end
        imem_rdata = w;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom();
        check("instr_latch", instr, w);
        check("imem_req_drop", {31'd0, imem_req}, 32'd0);

        if (legal && is_mem) begin
            wait_for(1, 10, "dmem_req_wait");
            check("dmem_we", {31'd0, dmem_we}, {31'd0, op == OP_ST});
            for (int k = 0; k < dw; k++) begin
                @(negedge clk);
                check("dmem_req_hold", {31'd0, dmem_req}, 32'd1);
            end
            dmem_ready = 1'b1;
            @(negedge clk);
            dmem_ready = 1'b0;
            check("dmem_req_drop", {31'd0, dmem_req}, 32'd0);
        end

        if (halt_exp) begin
            wait_for(3, 10, "halt_wait");
            check("halt_illegal", {31'd0, illegal}, 32'd1);
            check("halt_pc", pc, m_pc);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("halt_no_imem_req", {31'd0, imem_req}, 32'd0);
            end
        end else begin
            wait_for(2, 40, "retire_wait");
            m_pc = npc;
            m_instret = m_instret + 32'd1;
        end
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (retire) begin
                    check("retire_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("retire_pc", pc, e.pc);
                        check("retire_instret", instret, e.cnt);
                        check("retire_cycle", cyc, e.cyc);
                    end
                end
                if (rf_we) begin
                    check("rf_we_expected", {31'd0, wb_q.size() > 0}, 32'd1);
                    if (wb_q.size() > 0)
                        check("wb_sel", {30'd0, wb_sel}, {30'd0, wb_q.pop_front()});
                end
                if (rf_we || retire)
                    check("no_dmem_with_rf_retire", {31'd0, dmem_req}, 32'd0);
                if (state == 3'd2)
                    check("alu_b_sel", {31'd0, alu_b_sel}, {31'd0, exp_alub});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w, tg, r;
        logic [6:0]  op;
        do_reset();
        run_instr(32'h002081B3, 1'b0, 32'h0, 0, 0);            // ADD
        check("add_pc", pc, 32'h104);
        check("add_instret", instret, 32'd1);
        run_instr(32'h0000A183, 1'b0, 32'h0, 0, 3);            // LW, 3 wait cycles
        run_instr(32'h00208063, 1'b1, 32'h200, 0, 0);          // BEQ taken
        check("beq_taken_pc", pc, 32'h200);
        run_instr(32'h00208063, 1'b0, 32'h300, 0, 0);          // BEQ not taken
        check("beq_fall_pc", pc, 32'h204);

        for (int n = 0; n < 150; n++) begin
            op = rand_op();
            r  = $urandom();
            w  = {r[31:7], op};
            tg = $urandom() & 32'hFFFF_FFFC;
            run_instr(w, 1'($urandom_range(0, 1)), tg, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        run_instr(32'h0020006F, 1'b0, 32'h202, 0, 0);          // JAL misaligned
        check("jal_mis_state", {29'd0, state}, 32'd5);
        do_reset();
        run_instr(32'h0000007F, 1'b0, 32'h0, 1, 0);            // illegal opcode
        do_reset();
        check("illegal_cleared", {31'd0, illegal}, 32'd0);
        run_instr(32'h00208063, 1'b1, 32'h206, 0, 0);          // taken branch, misaligned
        do_reset();

        // reset during a MEM wait
        run_instr(32'h002081B3, 1'b0, 32'h0, 0, 0);
        wait_for(0, 10, "imem_req_wait");
        exp_alub   = 1'b1;
        imem_rdata = 32'h0000A183;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        wait_for(1, 10, "dmem_req_wait");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_pc = RPC;
        m_instret = 32'd0;
        check("memrst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("memrst_instret", instret, 32'd0);
        check("memrst_state", {29'd0, state}, 32'd0);
        check("memrst_pc", pc, RPC);

        // PC wrap
        run_instr(32'h0000006F, 1'b0, 32'hFFFF_FFFC, 0, 0);
        run_instr(32'h002081B3, 1'b0, 32'h0, 0, 0);
        check("wrap_pc", pc, 32'h0);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size() + wb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
